spike_dispatcher: RTL and testbench
===================================

SPIKE_DISPATCHER -- requirements
Module: spike_dispatcher

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of the event word read from the upstream FIFO.
REQ-002 SHALL have parameter NID_WIDTH, default 10: source-neuron ID width, taken from event bits [NID_WIDTH-1:0].
REQ-003 SHALL have parameter FANOUT_LOG2, default 4: log2 of synapses per source neuron (FANOUT = 2**FANOUT_LOG2).
REQ-004 SHALL have port clk  in  1: single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  in  1: synchronous, active-high reset.
REQ-006 SHALL have port enable  in  1: when high, permits popping new events.
REQ-007 SHALL have port fifo_empty  in  1: upstream FIFO empty flag.
REQ-008 SHALL have port fifo_rd_data  in  DATA_WIDTH: upstream FIFO head word, show-ahead (valid whenever fifo_empty=0).
REQ-009 SHALL have port fifo_rd_en  out  1: pop strobe to the upstream FIFO.
REQ-010 SHALL have port out_valid  out  1: synapse address valid.
REQ-011 SHALL have port out_ready  in  1: downstream accepts the address.
REQ-012 SHALL have port out_addr  out  NID_WIDTH+FANOUT_LOG2: synapse address {nid, index}.
REQ-013 SHALL have port out_last  out  1: marks the final index (FANOUT-1) of an event.
REQ-014 SHALL have port tick  out  1: one-cycle timestep-boundary pulse.
REQ-015 SHALL have port busy  out  1: high in any state other than IDLE.
REQ-016 SHALL have ports event_count and tick_count  out  16 each: statistics (see Configuration).

Function
REQ-017 SHALL implement FSM states IDLE, EMIT, TICK.
REQ-018 In IDLE with enable=1 and fifo_empty=0, SHALL assert fifo_rd_en for exactly that cycle and capture fifo_rd_data.
REQ-019 A captured word with bit DATA_WIDTH-1 = 1 is a marker: next state TICK; otherwise next state EMIT with nid = bits [NID_WIDTH-1:0] and index = 0.
REQ-020 Event bits between NID_WIDTH and DATA_WIDTH-2 SHALL be ignored.
REQ-021 In EMIT, SHALL drive out_valid=1, out_addr={nid,index} and out_last=(index==FANOUT-1).
REQ-022 On out_valid&&out_ready in EMIT: if out_last, return to IDLE; else increment index.
REQ-023 While out_valid=1 and out_ready=0, out_addr and out_last SHALL hold stable.
REQ-024 In TICK, SHALL assert tick for exactly one cycle, then return to IDLE.
REQ-025 fifo_rd_en SHALL never be asserted when fifo_empty=1 or when the state is not IDLE.
REQ-026 Latency: with the head valid at cycle T in IDLE, the first out_valid (or tick) SHALL occur at T+1.
REQ-027 Throughput with out_ready held at 1: FANOUT+1 cycles per spike event and 2 cycles per marker.
REQ-028 Deasserting enable mid-event SHALL NOT abort the event; it only blocks the next pop.

Reset
REQ-029 rst SHALL force state IDLE, index 0, and outputs fifo_rd_en, out_valid, out_last, tick, busy, event_count, tick_count and out_addr all to 0.
REQ-030 A reset during EMIT SHALL drop the in-flight event, which is not re-read.

Configuration
REQ-031 With macro SPIKE_DISPATCH_STATS_EN defined, event_count SHALL increment per popped spike event and tick_count per popped marker, both saturating at 16'hFFFF.
REQ-032 Without SPIKE_DISPATCH_STATS_EN, both counter ports SHALL be present but tied to 0, and no counter logic SHALL be generated.

Structure
REQ-033 Package spike_dispatch_pkg SHALL hold the FSM state typedef, the marker bit position rule, and the counter width constant (16).
REQ-034 The saturating counters SHALL be one sub-module, sat_counter, instantiated twice under the macro.

Verification
REQ-035 Single event nid=5, FANOUT=16, out_ready=1: one fifo_rd_en pulse, addresses 0x050..0x05F on consecutive cycles, out_last only on 0x05F, busy low after.
REQ-036 Marker word 0x80000000: one fifo_rd_en pulse, one tick pulse at T+1, no out_valid.
REQ-037 Backpressure: out_ready toggled 1/0 every cycle for nid=3: addresses held stable while stalled, all 16 delivered in order, no extra pops.
REQ-038 Empty FIFO or enable=0: fifo_rd_en never asserted; enable dropped at index 7 lets the event finish through index 15, then no further pop.
REQ-039 rst asserted at index 4: next cycle state is IDLE and all outputs are 0; the next FIFO word is processed normally afterward.
REQ-040 With SPIKE_DISPATCH_STATS_EN, 3 events plus 2 markers give event_count=3 and tick_count=2; with the counter preloaded to 0xFFFF it holds at 0xFFFF. Without the macro, both read 0.

Source files
------------

// File: rtl/spike_dispatch_pkg.sv
// spike_dispatch_pkg
//   Shared definitions for the spike dispatcher:
//   - state_t     : dispatcher FSM state encoding
//   - CNT_WIDTH   : width of the statistics counters
//   - marker_bit(): position of the timestep-marker flag in an event word
package spike_dispatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_TICK = 2'd2
  } state_t;

  localparam int CNT_WIDTH = 16;

  // The marker flag is always the most significant bit of the event word.
  function automatic int marker_bit(input int data_width);
    return data_width - 1;
  endfunction

endpackage

// File: rtl/spike_dispatcher_sat_counter.sv
// sat_counter
//   Up-counter that sticks at all-ones instead of wrapping.
//   Ports:
//     clk        in  : clock, rising edge
//     rst        in  : synchronous active-high reset (clears count)
//     inc        in  : increment request (ignored once saturated)
//     load       in  : load load_value (takes priority over inc)
//     load_value in  : value to load
//     count      out : current count
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/spike_dispatcher.sv
// spike_dispatcher
//   Pops event words from a show-ahead FIFO and expands each spike event into
//   FANOUT synapse addresses {nid, index}. Words with the MSB set are timestep
//   markers and produce a single-cycle tick pulse instead.
//
//   Optional feature: define SPIKE_DISPATCH_STATS_EN to build saturating
//   event/marker counters; otherwise event_count/tick_count are tied to 0.
//
//   Ports:
//     clk           in  : clock, rising edge
//     rst           in  : synchronous active-high reset
//     enable        in  : allows new events to be popped
//     fifo_empty    in  : upstream FIFO empty
//     fifo_rd_data  in  : upstream FIFO head word (show-ahead)
//     fifo_rd_en    out : pop strobe (combinational, IDLE only)
//     out_valid     out : synapse address valid
//     out_ready     in  : downstream accepts address
//     out_addr      out : {nid, index}
//     out_last      out : final index of the current event
//     tick          out : one-cycle timestep pulse
//     busy          out : FSM not in IDLE
//     event_count   out : popped spike events (stats build)
//     tick_count    out : popped markers (stats build)
//
//   FSM states:
//     state   | meaning
//     IDLE    | waiting for enable and a non-empty FIFO; pops on entry condition
//     EMIT    | presenting {nid, index}, advancing on each accepted address
//     TICK    | one-cycle tick pulse for a marker word
module spike_dispatcher
  import spike_dispatch_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int NID_WIDTH   = 10,
  parameter int FANOUT_LOG2 = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          fifo_empty,
  input  logic [DATA_WIDTH-1:0]         fifo_rd_data,
  output logic                          fifo_rd_en,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [NID_WIDTH+FANOUT_LOG2-1:0] out_addr,
  output logic                          out_last,
  output logic                          tick,
  output logic                          busy,
  output logic [CNT_WIDTH-1:0]          event_count,
  output logic [CNT_WIDTH-1:0]          tick_count
);

  localparam int MARKER_BIT = marker_bit(DATA_WIDTH);
  localparam logic [FANOUT_LOG2-1:0] LAST_IDX = '1;

  state_t                 state;
  logic [NID_WIDTH-1:0]   nid;
  logic [FANOUT_LOG2-1:0] index;
  logic                   pop;
  logic                   is_marker;
  logic                   unused_bits;

  // Pop is combinational so the head word is consumed in the same cycle it is
  // seen; reset gates it so nothing is lost while reset is held.
  assign pop        = !rst && (state == ST_IDLE) && enable && !fifo_empty;
  assign fifo_rd_en = pop;
  assign is_marker  = fifo_rd_data[MARKER_BIT];
  assign out_addr   = {nid, index};

  // Payload bits between the neuron ID and the marker flag carry nothing here.
  assign unused_bits = ^fifo_rd_data[DATA_WIDTH-2:NID_WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      nid       <= '0;
      index     <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      tick      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pop) begin
            busy <= 1'b1;
            if (is_marker) begin
              state <= ST_TICK;
              tick  <= 1'b1;
            end else begin
              state     <= ST_EMIT;
              nid       <= fifo_rd_data[NID_WIDTH-1:0];
              index     <= '0;
              out_valid <= 1'b1;
              // FANOUT_LOG2 >= 1, so index 0 is never the last one.
              out_last  <= 1'b0;
            end
          end
        end

        ST_EMIT: begin
          if (out_ready) begin
            if (out_last) begin
              state     <= ST_IDLE;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              busy      <= 1'b0;
            end else begin
              index    <= index + 1'b1;
              out_last <= (index == LAST_IDX - 1'b1);
            end
          end
        end

        ST_TICK: begin
          state <= ST_IDLE;
          tick  <= 1'b0;
          busy  <= 1'b0;
        end

        default: begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
          tick      <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

`ifdef SPIKE_DISPATCH_STATS_EN
  sat_counter #(
    .WIDTH(CNT_WIDTH)
  ) u_event_cnt (
    .clk        (clk),
    .rst        (rst),
    .inc        (pop && !is_marker),
    .load       (1'b0),
    .load_value ({CNT_WIDTH{1'b0}}),
    .count      (event_count)
  );

  sat_counter #(
    .WIDTH(CNT_WIDTH)
  ) u_tick_cnt (
    .clk        (clk),
    .rst        (rst),
    .inc        (pop && is_marker),
    .load       (1'b0),
    .load_value ({CNT_WIDTH{1'b0}}),
    .count      (tick_count)
  );
`else
  assign event_count = '0;
  assign tick_count  = '0;
`endif

endmodule

// File: tb/tb_spike_dispatcher.sv
module tb_spike_dispatcher;

  localparam int DATA_WIDTH  = 32;
  localparam int NID_WIDTH   = 10;
  localparam int FANOUT_LOG2 = 4;
  localparam int FANOUT      = 1 << FANOUT_LOG2;
  localparam int AW          = NID_WIDTH + FANOUT_LOG2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst = 1'b1;
  logic                  enable = 1'b0;
  logic                  fifo_empty = 1'b1;
  logic [DATA_WIDTH-1:0] fifo_rd_data = '0;
  logic                  fifo_rd_en;
  logic                  out_valid;
  logic                  out_ready = 1'b1;
  logic [AW-1:0]         out_addr;
  logic                  out_last;
  logic                  tick;
  logic                  busy;
  logic [15:0]           event_count;
  logic [15:0]           tick_count;

  logic                  sc_inc = 1'b0;
  logic                  sc_load = 1'b0;
  logic [15:0]           sc_load_value = '0;
  logic [15:0]           sc_count;

  spike_dispatcher #(
    .DATA_WIDTH (DATA_WIDTH),
    .NID_WIDTH  (NID_WIDTH),
    .FANOUT_LOG2(FANOUT_LOG2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .fifo_empty  (fifo_empty),
    .fifo_rd_data(fifo_rd_data),
    .fifo_rd_en  (fifo_rd_en),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_addr    (out_addr),
    .out_last    (out_last),
    .tick        (tick),
    .busy        (busy),
    .event_count (event_count),
    .tick_count  (tick_count)
  );

  sat_counter #(.WIDTH(16)) u_sc (
    .clk       (clk),
    .rst       (rst),
    .inc       (sc_inc),
    .load      (sc_load),
    .load_value(sc_load_value),
    .count     (sc_count)
  );

  typedef struct packed {
    int            seq;
    logic          is_tick;
    logic [AW-1:0] addr;
    logic          last;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] fifo_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int n_pushed = 0;
  int pops     = 0;
  int cyc      = 0;
  int ready_mode = 0;   // 0: always ready, 1: toggle, 2: random
  int m_events = 0;
  int m_ticks  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Stimulus side: the FIFO model receives the word and the scoreboard gets
  // every response the word should produce, derived arithmetically.
  task automatic push_word(input logic [31:0] w);
    exp_t e;
    fifo_q.push_back(w);
    if (w[31]) begin
      e.seq = n_pushed; e.is_tick = 1'b1; e.addr = '0; e.last = 1'b0;
      exp_q.push_back(e);
    end else begin
      for (int i = 0; i < FANOUT; i++) begin
        e.seq     = n_pushed;
        e.is_tick = 1'b0;
        e.addr    = AW'(int'(w[NID_WIDTH-1:0]) * FANOUT + i);
        e.last    = (i == FANOUT - 1);
        exp_q.push_back(e);
      end
    end
    n_pushed++;
  endtask

  task automatic sb_compare(input logic is_tick);
    exp_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_output: got tick=%0b addr=0x%0h with nothing expected (cycle %0d)",
               is_tick, out_addr, cyc);
    end else begin
      e = exp_q.pop_front();
      check("out_kind", 64'(is_tick), 64'(e.is_tick));
      if (!is_tick) begin
        check("out_addr", 64'(out_addr), 64'(e.addr));
        check("out_last", 64'(out_last), 64'(e.last));
      end
    end
  endtask

  // Driver: FIFO head and out_ready, refreshed at negedge+2.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      fifo_empty   = (fifo_q.size() == 0);
      fifo_rd_data = fifo_empty ? 32'h0 : fifo_q[0];
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ~out_ready;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: samples at negedge+3, after every input for the next edge is set.
  logic        prev_rst = 1'b0, prev_pop = 1'b0, prev_stall = 1'b0;
  logic        prev_tick = 1'b0, prev_busy = 1'b0, prev_last = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  logic        tp_armed = 1'b0, last_marker = 1'b0;
  int          pop_cyc = 0;

  initial begin
    forever begin
      @(negedge clk);
      #3;
      cyc++;
      if (rst) begin
        if (prev_rst)
          check("reset_outputs",
                64'({fifo_rd_en, out_valid, out_last, tick, busy, out_addr, event_count, tick_count}), 64'h0);
        while (exp_q.size() > 0 && exp_q[0].seq < pops) void'(exp_q.pop_front());
        m_events = 0;
        m_ticks  = 0;
        tp_armed = 1'b0;
      end else begin
        check("rd_en_legal", 64'(fifo_rd_en && (fifo_empty || busy || !enable)), 64'h0);
        if (prev_pop) check("first_out_latency", 64'(out_valid || tick), 64'h1);
        if (prev_stall) begin
          check("stall_valid", 64'(out_valid), 64'h1);
          check("stall_addr", 64'(out_addr), 64'(prev_addr));
          check("stall_last", 64'(out_last), 64'(prev_last));
        end
        if (tick) begin
          check("tick_width", 64'(prev_tick), 64'h0);
          sb_compare(1'b1);
        end
        if (out_valid && out_ready) sb_compare(1'b0);
`ifdef SPIKE_DISPATCH_STATS_EN
        check("event_count", 64'(event_count), 64'(m_events));
        check("tick_count", 64'(tick_count), 64'(m_ticks));
`else
        check("event_count_off", 64'(event_count), 64'h0);
        check("tick_count_off", 64'(tick_count), 64'h0);
`endif
        if (tp_armed && prev_busy && !busy) begin
          check("throughput_cycles", 64'(cyc - pop_cyc), last_marker ? 64'd2 : 64'(FANOUT + 1));
          tp_armed = 1'b0;
        end
        if (fifo_rd_en) begin
          last_marker = (fifo_q.size() > 0) ? fifo_q[0][31] : 1'b0;
          if (fifo_q.size() > 0) void'(fifo_q.pop_front());
          pops++;
          if (last_marker) m_ticks  = (m_ticks  < 65535) ? m_ticks + 1  : m_ticks;
          else             m_events = (m_events < 65535) ? m_events + 1 : m_events;
          pop_cyc  = cyc;
          tp_armed = (ready_mode == 0);
        end
      end
      prev_rst   = rst;
      prev_pop   = fifo_rd_en && !rst;
      prev_stall = out_valid && !out_ready && !rst;
      prev_addr  = out_addr;
      prev_last  = out_last;
      prev_tick  = tick;
      prev_busy  = busy;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_idle(input int max_cycles);
    bit done = 1'b0;
    for (int k = 0; k < max_cycles && !done; k++) begin
      step();
      if (fifo_q.size() == 0 && !busy) done = 1'b1;
    end
    check("idle_reached", 64'(done), 64'h1);
  endtask

  task automatic wait_index(input int idx, input int max_cycles, input string name);
    bit found = 1'b0;
    for (int k = 0; k < max_cycles && !found; k++) begin
      step();
      if (out_valid && int'(out_addr[FANOUT_LOG2-1:0]) == idx) found = 1'b1;
    end
    check(name, 64'(found), 64'h1);
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    w[31] = ($urandom_range(0, 3) == 0);
    return w;
  endfunction

  int p0;

  initial begin
    repeat (3) step();
    rst    = 1'b0;
    enable = 1'b1;

    // single event nid=5, always ready
    p0 = pops;
    push_word(32'h0000_0005);
    wait_idle(100);
    check("nid5_pops", 64'(pops - p0), 64'd1);

    // marker word
    p0 = pops;
    push_word(32'h8000_0000);
    wait_idle(20);
    check("marker_pops", 64'(pops - p0), 64'd1);

    // backpressure: ready toggles every cycle
    ready_mode = 1;
    p0 = pops;
    push_word(32'h0000_0003);
    wait_idle(100);
    check("bp_pops", 64'(pops - p0), 64'd1);
    ready_mode = 0;

    // empty FIFO, then disabled with words waiting
    repeat (10) step();
    enable = 1'b0;
    p0 = pops;
    push_word(32'h0000_0009);
    push_word(32'h7FF0_0011);
    repeat (10) step();
    check("disabled_no_pop", 64'(pops - p0), 64'd0);

    // enable dropped mid-event: event completes, next word stays put
    enable = 1'b1;
    wait_index(7, 50, "reach_index7");
    enable = 1'b0;
    for (int k = 0; k < 40 && busy; k++) step();
    repeat (8) step();
    check("enable_drop_pops", 64'(pops - p0), 64'd1);
    check("enable_drop_fifo_left", 64'(fifo_q.size()), 64'd1);
    enable = 1'b1;
    wait_idle(100);

    // reset at index 4 drops the event; the following word runs normally
    p0 = pops;
    push_word(32'h0000_000C);
    push_word(32'h0000_0006);
    wait_index(4, 50, "reach_index4");
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    wait_idle(100);
    check("reset_drop_pops", 64'(pops - p0), 64'd2);

    // randomized traffic
    ready_mode = 2;
    repeat (400) begin
      step();
      if (fifo_q.size() < 3 && $urandom_range(0, 3) == 0) push_word(rand_word());
      enable = ($urandom_range(0, 7) != 0);
    end
    enable = 1'b1;
    wait_idle(300);
    ready_mode = 0;

    // statistics: 3 events and 2 markers after a fresh reset
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    push_word(32'h0000_0001);
    push_word(32'h8000_0000);
    push_word(32'h0000_0002);
    push_word(32'h8000_1234);
    push_word(32'h0000_0003);
    wait_idle(200);
`ifdef SPIKE_DISPATCH_STATS_EN
    check("stats_events", 64'(event_count), 64'd3);
    check("stats_ticks", 64'(tick_count), 64'd2);
`else
    check("stats_events_off", 64'(event_count), 64'd0);
    check("stats_ticks_off", 64'(tick_count), 64'd0);
`endif

    // saturating counter: preload near the top, then keep incrementing
    sc_load_value = 16'hFFFE;
    sc_load = 1'b1;
    step();
    sc_load = 1'b0;
    sc_inc  = 1'b1;
    step();
    check("sat_reach_max", 64'(sc_count), 64'hFFFF);
    step();
    step();
    check("sat_hold_max", 64'(sc_count), 64'hFFFF);
    sc_load_value = 16'h0010;
    sc_load = 1'b1;
    sc_inc  = 1'b0;
    step();
    sc_load = 1'b0;
    sc_inc  = 1'b1;
    step();
    step();
    sc_inc = 1'b0;
    step();
    check("sat_count_up", 64'(sc_count), 64'h0012);

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
